alu_arbiter_ctrl: RTL and testbench

- Shares the single combinational 8-bit ALU between two requesters: A (control unit, execute stage) and B (address/branch unit).
- Arbitrates round-robin and latches operands and opcode, so ALU inputs stay stable while the ALU settles.
- Captures the ALU result, derives status flags and returns a response to the granted requester over a valid/ready handshake.
- Traps divide-by-zero so a zero divisor never reaches the ALU.

---
 rtl/alu_arbiter_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: round-robin owner of one shared combinational 8-bit ALU for requesters A and B.
// Latency: accept at cycle N -> owner rsp_valid at N+EXEC_CYCLES+1; one op per EXEC_CYCLES+2 cycles.
// Backpressure: response held stable until owner rsp_ready; no request is accepted until back in IDLE.
//
// Optional feature macro: ALU_ARB_STATS_EN adds saturating a_count/b_count/divz_count outputs.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   a_req_valid/a_req_ready         A request handshake; a_op/a_in1/a_in2 sampled only on accept
//   a_rsp_valid/a_rsp_ready         A response handshake
//   b_*                             same set for requester B
//   rsp_data, rsp_flags             shared response payload; flags = {divz, carry, neg, zero}
//   alu_in1, alu_in2, alu_sel       registered operands/selector to the ALU
//   alu_out, alu_carry              ALU result and carryOut
//   busy                            controller not in IDLE
//
// Opcode encoding shared with the ALU (OP_*): 0 default path, 1 ADD, 2 SUB, 3 MUL, 4 DIV,
// 5 AND, 6 OR, 7 XOR, 8 CMP. Only the ones this controller interprets are declared below.

module alu_arbiter_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SEL_W       = 5,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [SEL_W-1:0] a_op,
    input  logic [WIDTH-1:0] a_in1,
    input  logic [WIDTH-1:0] a_in2,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,

    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [SEL_W-1:0] b_op,
    input  logic [WIDTH-1:0] b_in1,
    input  logic [WIDTH-1:0] b_in2,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,

    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,

    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count,
    output logic [7:0]       divz_count
`endif
);

    localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(4);

    // EXEC_CYCLES is limited to 1..15, so the settle counter fits in 4 bits.
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation as presented to the ALU.
    typedef struct packed {
        logic [SEL_W-1:0] op;
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
    } alu_req_t;

    typedef struct packed {
        logic divz;
        logic carry;
        logic neg;
        logic zero;
    } flags_t;

    state_t           state_q;
    state_t           state_d;
    alu_req_t         alu_q;
    logic             owner_q;
    logic             rr_last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             divz_q;
    logic [WIDTH-1:0] rsp_data_q;
    flags_t           flags_q;

    // ------------------------------------------------------------------
    // Arbitration (IDLE only). On a tie the requester that did not own the
    // previous operation wins; a lone requester always wins.
    // ------------------------------------------------------------------
    logic     idle;
    logic     pick_a;
    logic     pick_b;
    logic     accept;
    alu_req_t win_req;
    logic     win_divz;

    assign idle   = (state_q == IDLE);
    assign pick_b = b_req_valid && (!a_req_valid || (rr_last_q == OWN_A));
    assign pick_a = a_req_valid && !pick_b;

    assign a_req_ready = idle && pick_a;
    assign b_req_ready = idle && pick_b;
    assign accept      = idle && (pick_a || pick_b);

    assign win_req  = pick_b ? '{op: b_op, in1: b_in1, in2: b_in2}
                             : '{op: a_op, in1: a_in1, in2: a_in2};
    assign win_divz = (win_req.op == OP_DIV) && (win_req.in2 == '0);

    // ------------------------------------------------------------------
    // Capture / response handshake
    // ------------------------------------------------------------------
    logic             exec_done;
    logic             rsp_hs;
    logic [WIDTH-1:0] result;
    logic             carry_defined;

    assign exec_done = (state_q == EXEC) && (cnt_q == '0);
    assign rsp_hs    = (state_q == RESP) &&
                       (((owner_q == OWN_A) && a_rsp_ready) ||
                        ((owner_q == OWN_B) && b_rsp_ready));

    // A trapped divide still drives the ALU default path, whose output is
    // meaningless here, so the result is forced to zero.
    assign result        = divz_q ? '0 : alu_out;
    assign carry_defined = (alu_q.op == OP_ADD) || (alu_q.op == OP_MUL);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = EXEC;
            EXEC: if (exec_done) state_d = RESP;
            RESP: if (rsp_hs)    state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q      <= '0;
            owner_q    <= OWN_A;
            rr_last_q  <= OWN_B;
            cnt_q      <= '0;
            divz_q     <= 1'b0;
            rsp_data_q <= '0;
            flags_q    <= '0;
        end else if (accept) begin
            owner_q   <= pick_b ? OWN_B : OWN_A;
            rr_last_q <= pick_b ? OWN_B : OWN_A;
            cnt_q     <= CNT_LOAD;
            divz_q    <= win_divz;
            // A zero divisor never reaches the ALU.
            alu_q     <= win_divz ? '0 : win_req;
        end else if (state_q == EXEC) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                rsp_data_q    <= result;
                flags_q.divz  <= divz_q;
                flags_q.carry <= carry_defined && alu_carry;
                flags_q.neg   <= result[WIDTH-1];
                flags_q.zero  <= (result == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_rsp_valid = (state_q == RESP) && (owner_q == OWN_A);
    assign b_rsp_valid = (state_q == RESP) && (owner_q == OWN_B);
    assign rsp_data    = rsp_data_q;
    assign rsp_flags   = flags_q;
    assign alu_in1     = alu_q.in1;
    assign alu_in2     = alu_q.in2;
    assign alu_sel     = alu_q.op;
    assign busy        = !idle;

`ifdef ALU_ARB_STATS_EN
    // Completed-response counters; all saturate rather than wrap.
    logic [15:0] a_cnt_q;
    logic [15:0] b_cnt_q;
    logic [7:0]  divz_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            divz_cnt_q <= '0;
        end else if (rsp_hs) begin
            if ((owner_q == OWN_A) && (a_cnt_q != '1)) a_cnt_q <= a_cnt_q + 16'd1;
            if ((owner_q == OWN_B) && (b_cnt_q != '1)) b_cnt_q <= b_cnt_q + 16'd1;
            if (flags_q.divz && (divz_cnt_q != '1))    divz_cnt_q <= divz_cnt_q + 8'd1;
        end
    end

    assign a_count    = a_cnt_q;
    assign b_count    = b_cnt_q;
    assign divz_count = divz_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a (bench).
// Backpressure: bench drives random response stalls on the owner's rsp_ready.

module tb_alu_arbiter_ctrl;

    localparam int EXEC_CYCLES = 1;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5;
    localparam logic [4:0] OP_OR  = 5'd6;
    localparam logic [4:0] OP_XOR = 5'd7;
    localparam logic [4:0] OP_CMP = 5'd8;
    localparam logic [4:0] OPS [8] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_CMP};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [4:0] a_op, b_op, alu_sel;
    logic [7:0] a_in1, a_in2, b_in1, b_in2;
    logic [7:0] rsp_data, alu_in1, alu_in2, alu_out;
    logic [3:0] rsp_flags;
    logic       alu_carry, busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] a_count, b_count;
    logic [7:0]  divz_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Observations collected by wait_rsp
    int          obs_lat;
    logic [7:0]  obs_data;
    logic [3:0]  obs_flags;
    logic [20:0] obs_alu;
    bit          obs_stray, obs_leak, obs_stable, obs_grant;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_ctrl #(.WIDTH(8), .SEL_W(5), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op), .a_in1(a_in1), .a_in2(a_in2),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op), .b_in1(b_in1), .b_in2(b_in2),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .a_count(a_count), .b_count(b_count), .divz_count(divz_count)
`endif
    );

    // Environment ALU: {carryOut, out}. Carry is deliberately noisy for ops where it is undefined,
    // and a zero divisor produces garbage, so the controller must mask/trap them.
    function automatic logic [8:0] alu_model(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [8:0]        s;
        logic [15:0]       p;
        logic signed [7:0] q;
        s = 9'h0;
        p = 16'h0;
        q = 8'sh0;
        case (op)
            OP_ADD: s = {1'b0, x} + {1'b0, y};
            OP_SUB: s = {1'b0, x} - {1'b0, y};
            OP_MUL: begin
                p = {8'h00, x} * {8'h00, y};
                s = {|p[15:8], p[7:0]};
            end
            OP_DIV: begin
                if (y == 8'h00) begin
                    s = 9'h1EE;
                end else begin
                    q = $signed(x) / $signed(y);
                    s = {1'b1, q};
                end
            end
            OP_AND: s = {1'b1, x & y};
            OP_OR:  s = {1'b1, x | y};
            OP_XOR: s = {1'b0, x ^ y};
            OP_CMP: s = {1'b1, x - y};
            default: s = 9'h1A5;
        endcase
        return s;
    endfunction

    always_comb {alu_carry, alu_out} = alu_model(alu_sel, alu_in1, alu_in2);

    // Expected response {flags, data} straight from the request as issued.
    function automatic logic [11:0] expect_rsp(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        logic       dz;
        logic [8:0] r;
        logic [7:0] d;
        logic       c;
        dz = (op == OP_DIV) && (y == 8'h00);
        r  = alu_model(op, x, y);
        d  = dz ? 8'h00 : r[7:0];
        c  = (!dz && (op == OP_ADD || op == OP_MUL)) ? r[8] : 1'b0;
        return {dz, c, d[7], (d == 8'h00), d};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons). Tasks enter and leave 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic drive_req(input bit who, input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
        if (who) begin
            b_req_valid = 1'b1; b_op = op; b_in1 = x; b_in2 = y;
        end else begin
            a_req_valid = 1'b1; a_op = op; a_in1 = x; a_in2 = y;
        end
    endtask

    task automatic apply_reset();
        clear_reqs();
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        to_next();
    endtask

    // Called right after the accept edge. Waits (bounded) for the owner's response, records what
    // was seen, holds rsp_ready low for 'stall' cycles, then optionally completes the handshake.
    task automatic wait_rsp(input bit who, input int stall, input bit hs);
        logic [20:0] snap;
        snap       = '0;
        obs_lat    = -1;
        obs_stray  = 1'b0;
        obs_leak   = 1'b0;
        obs_stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!a_req_valid) begin a_op = 5'($urandom); a_in1 = 8'($urandom); a_in2 = 8'($urandom); end
            if (!b_req_valid) begin b_op = 5'($urandom); b_in1 = 8'($urandom); b_in2 = 8'($urandom); end
            if (i == 1) snap = {alu_sel, alu_in1, alu_in2};
            else if ({alu_sel, alu_in1, alu_in2} !== snap) obs_stable = 1'b0;
            if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) obs_leak = 1'b1;
            if ((who ? a_rsp_valid : b_rsp_valid) !== 1'b0) obs_stray = 1'b1;
            if ((who ? b_rsp_valid : a_rsp_valid) === 1'b1) begin
                obs_lat = i;
                break;
            end
        end
        obs_alu   = snap;
        obs_data  = rsp_data;
        obs_flags = rsp_flags;
        if (obs_lat < 0) return;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if ({rsp_data, rsp_flags} !== {obs_data, obs_flags} ||
                (who ? b_rsp_valid : a_rsp_valid) !== 1'b1 ||
                (who ? a_rsp_valid : b_rsp_valid) !== 1'b0 ||
                {alu_sel, alu_in1, alu_in2} !== snap) obs_stable = 1'b0;
        end
        if (hs) begin
            if (who) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
            to_next();
            a_rsp_ready = 1'b0;
            b_rsp_ready = 1'b0;
        end
    endtask

    task automatic run_op(input bit who, input logic [4:0] op, input logic [7:0] x, input logic [7:0] y,
                          input int stall);
        drive_req(who, op, x, y);
        @(negedge clk);
        obs_grant = who ? (b_req_ready === 1'b1 && a_req_ready === 1'b0)
                        : (a_req_ready === 1'b1 && b_req_ready === 1'b0);
        to_next();
        clear_reqs();
        wait_rsp(who, stall, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_reqs();
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        a_op = '0; a_in1 = '0; a_in2 = '0; b_op = '0; b_in1 = '0; b_in2 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy, rsp_data, rsp_flags,
             alu_in1, alu_in2, alu_sel} !== '0)
            begin errors++; $display("FAIL reset_in: outputs got %h want 0", {a_req_ready, b_req_ready,
                a_rsp_valid, b_rsp_valid, busy, rsp_data, rsp_flags, alu_in1, alu_in2, alu_sel}); end
        @(negedge clk);
        rst_n = 1'b1;
        to_next();
        @(negedge clk);
        checks++;
        if ({a_rsp_valid, b_rsp_valid, busy, rsp_data, rsp_flags, alu_sel} !== '0)
            begin errors++; $display("FAIL reset_out: outputs got %h want 0", {a_rsp_valid, b_rsp_valid,
                busy, rsp_data, rsp_flags, alu_sel}); end
`ifdef ALU_ARB_STATS_EN
        checks++;
        if ({a_count, b_count, divz_count} !== '0)
            begin errors++; $display("FAIL reset_stats: got %h want 0", {a_count, b_count, divz_count}); end
`endif
        to_next();
    endtask

    task automatic test_single_add();
        run_op(1'b0, OP_ADD, 8'h05, 8'h03, 0);
        checks++;
        if (!obs_grant) begin errors++; $display("FAIL add_grant: A not granted alone"); end
        checks++;
        if (obs_lat !== EXEC_CYCLES + 1) begin errors++; $display("FAIL add_latency: got %0d want %0d", obs_lat, EXEC_CYCLES + 1); end
        checks++;
        if ({obs_flags, obs_data} !== 12'h008) begin errors++; $display("FAIL add_rsp: got %h want 008", {obs_flags, obs_data}); end
        checks++;
        if (obs_alu !== {OP_ADD, 8'h05, 8'h03}) begin errors++; $display("FAIL add_alu_in: got %h want %h", obs_alu, {OP_ADD, 8'h05, 8'h03}); end
        checks++;
        if (obs_stray) begin errors++; $display("FAIL add_stray: b_rsp_valid got 1 want 0"); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL add_idle: busy got %b want 0", busy); end
        to_next();
    endtask

    task automatic test_tie();
        apply_reset();
        drive_req(1'b0, OP_SUB, 8'h02, 8'h05);
        drive_req(1'b1, OP_AND, 8'hF0, 8'h3C);
        @(negedge clk);
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b10) begin errors++; $display("FAIL tie_first: ready got %b want 10", {a_req_ready, b_req_ready}); end
        to_next();
        a_req_valid = 1'b0;
        wait_rsp(1'b0, 0, 1'b1);
        checks++;
        if ({obs_flags, obs_data} !== 12'h2FD) begin errors++; $display("FAIL tie_sub_rsp: got %h want 2fd", {obs_flags, obs_data}); end
        checks++;
        if (obs_leak) begin errors++; $display("FAIL tie_busy_ready: b_req_ready got 1 want 0 while busy"); end
        @(negedge clk);
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b01) begin errors++; $display("FAIL tie_second: ready got %b want 01", {a_req_ready, b_req_ready}); end
        to_next();
        b_req_valid = 1'b0;
        wait_rsp(1'b1, 0, 1'b1);
        checks++;
        if ({obs_flags, obs_data} !== 12'h030) begin errors++; $display("FAIL tie_and_rsp: got %h want 030", {obs_flags, obs_data}); end
        // Repeated tie: A wins again; A then withdraws before the edge, which must change nothing.
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b0, OP_OR, 8'h11, 8'h22);
            drive_req(1'b1, OP_OR, 8'h33, 8'h44);
            @(negedge clk);
            checks++;
            if ({a_req_ready, b_req_ready} !== 2'b10) begin errors++; $display("FAIL tie_repeat%0d: ready got %b want 10", k, {a_req_ready, b_req_ready}); end
            clear_reqs();
            to_next();
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL tie_withdraw%0d: busy got %b want 0", k, busy); end
            to_next();
        end
    endtask

    task automatic test_divz();
        run_op(1'b1, OP_DIV, 8'h40, 8'h00, 2);
        checks++;
        if (!obs_grant) begin errors++; $display("FAIL divz_grant: B not granted"); end
        checks++;
        if ({obs_flags, obs_data} !== 12'h900) begin errors++; $display("FAIL divz_rsp: got %h want 900", {obs_flags, obs_data}); end
        checks++;
        if (obs_alu !== 21'h0 || !obs_stable) begin errors++; $display("FAIL divz_alu: alu got %h stable %b want 0 stable 1", obs_alu, obs_stable); end
        checks++;
        if (obs_stray) begin errors++; $display("FAIL divz_stray: a_rsp_valid got 1 want 0"); end
    endtask

    task automatic test_stall();
        drive_req(1'b0, OP_CMP, 8'h03, 8'h03);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL stall_grant: a_req_ready got %b want 1", a_req_ready); end
        to_next();
        a_req_valid = 1'b0;
        drive_req(1'b1, OP_ADD, 8'h01, 8'h01);
        wait_rsp(1'b0, 0, 1'b0);
        checks++;
        if (obs_lat !== EXEC_CYCLES + 1 || obs_leak) begin errors++; $display("FAIL stall_exec: lat got %0d leak %b want %0d leak 0", obs_lat, obs_leak, EXEC_CYCLES + 1); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({a_rsp_valid, busy, b_req_ready, rsp_flags, rsp_data} !== {1'b1, 1'b1, 1'b0, 4'h1, 8'h00})
                begin errors++; $display("FAIL stall_hold%0d: {vld,busy,brdy,flags,data} got %h want %h", i,
                    {a_rsp_valid, busy, b_req_ready, rsp_flags, rsp_data}, {1'b1, 1'b1, 1'b0, 4'h1, 8'h00}); end
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        b_req_valid = 1'b0;
        to_next();
        a_rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, a_rsp_valid} !== 2'b00) begin errors++; $display("FAIL stall_release: {busy,vld} got %b want 00", {busy, a_rsp_valid}); end
        to_next();
    endtask

    task automatic test_reset_mid();
        bit quiet;
        drive_req(1'b0, OP_ADD, 8'h10, 8'h20);
        @(negedge clk);
        to_next();
        clear_reqs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy, rsp_data, rsp_flags,
             alu_in1, alu_in2, alu_sel} !== '0)
            begin errors++; $display("FAIL rst_mid: outputs got %h want 0", {a_req_ready, b_req_ready,
                a_rsp_valid, b_rsp_valid, busy, rsp_data, rsp_flags, alu_in1, alu_in2, alu_sel}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL rst_mid_quiet: response or busy seen after release"); end
        to_next();
        run_op(1'b1, OP_XOR, 8'h5A, 8'h0F, 1);
        checks++;
        if (obs_lat !== EXEC_CYCLES + 1 || {obs_flags, obs_data} !== 12'h055)
            begin errors++; $display("FAIL rst_mid_next: lat %0d rsp %h want %0d 055", obs_lat, {obs_flags, obs_data}, EXEC_CYCLES + 1); end
    endtask

    task automatic test_back_to_back();
        int prev, n_acc;
        prev  = -1;
        n_acc = 0;
        a_rsp_ready = 1'b1;
        drive_req(1'b0, OP_ADD, 8'h01, 8'h01);
        for (int i = 0; i < 4 * (EXEC_CYCLES + 2); i++) begin
            @(negedge clk);
            if (a_req_ready === 1'b1) begin
                n_acc++;
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev !== EXEC_CYCLES + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - prev, EXEC_CYCLES + 2); end
                end
                prev = cyc;
            end
        end
        clear_reqs();
        repeat (EXEC_CYCLES + 3) to_next();
        a_rsp_ready = 1'b0;
        checks++;
        if (n_acc !== 4 || busy !== 1'b0) begin errors++; $display("FAIL b2b_count: accepts %0d busy %b want 4 0", n_acc, busy); end
    endtask

    task automatic test_random(input int n);
        int         last;
        bit         av, bv, win;
        logic [4:0] oa, ob, wop;
        logic [7:0] xa, ya, xb, yb, wx, wy;
        logic [11:0] exp;
        apply_reset();
        last = 1;
        for (int it = 0; it < n; it++) begin
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            oa = OPS[$urandom_range(0, 7)]; xa = 8'($urandom); ya = 8'($urandom);
            ob = OPS[$urandom_range(0, 7)]; xb = 8'($urandom); yb = 8'($urandom);
            if (oa == OP_DIV && $urandom_range(0, 2) == 0) ya = 8'h00;
            if (ob == OP_DIV && $urandom_range(0, 2) == 0) yb = 8'h00;
            if (av) drive_req(1'b0, oa, xa, ya);
            if (bv) drive_req(1'b1, ob, xb, yb);
            win = (av && bv) ? (last == 0) : bv;
            @(negedge clk);
            checks++;
            if ({a_req_ready, b_req_ready} !== {av && !win, bv && win})
                begin errors++; $display("FAIL rnd_grant%0d: ready got %b want %b", it, {a_req_ready, b_req_ready}, {av && !win, bv && win}); end
            if (!(av || bv) || $urandom_range(0, 5) == 0) begin
                clear_reqs();
                to_next();
                continue;
            end
            to_next();
            clear_reqs();
            wop = win ? ob : oa;
            wx  = win ? xb : xa;
            wy  = win ? yb : ya;
            exp = expect_rsp(wop, wx, wy);
            wait_rsp(win, $urandom_range(0, 3), 1'b1);
            checks++;
            if (obs_lat !== EXEC_CYCLES + 1) begin errors++; $display("FAIL rnd_lat%0d: got %0d want %0d", it, obs_lat, EXEC_CYCLES + 1); end
            checks++;
            if ({obs_flags, obs_data} !== exp)
                begin errors++; $display("FAIL rnd_rsp%0d: op %0d %h,%h got %h want %h", it, wop, wx, wy, {obs_flags, obs_data}, exp); end
            checks++;
            if (obs_alu !== (exp[11] ? 21'h0 : {wop, wx, wy}))
                begin errors++; $display("FAIL rnd_alu%0d: got %h want %h", it, obs_alu, exp[11] ? 21'h0 : {wop, wx, wy}); end
            checks++;
            if (obs_stray || obs_leak || !obs_stable)
                begin errors++; $display("FAIL rnd_hs%0d: stray %b leak %b stable %b want 0 0 1", it, obs_stray, obs_leak, obs_stable); end
            last = win;
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        run_op(1'b0, OP_ADD, 8'h01, 8'h02, 0);
        run_op(1'b1, OP_DIV, 8'h09, 8'h00, 1);
        run_op(1'b0, OP_SUB, 8'h07, 8'h02, 2);
        run_op(1'b1, OP_MUL, 8'h03, 8'h04, 0);
        run_op(1'b0, OP_XOR, 8'hFF, 8'h0F, 0);
        @(negedge clk);
        checks++;
        if ({a_count, b_count, divz_count} !== {16'd3, 16'd2, 8'd1})
            begin errors++; $display("FAIL stats: a %0d b %0d divz %0d want 3 2 1", a_count, b_count, divz_count); end
        to_next();
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_divz();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random(80);
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
